// File: rtl/alu_issue_ctrl_if.sv
// Handshake and operand bundle between decode, the issue sequencer, the ALU and writeback.
// Combinational wiring only; no latency.
// Backpressure is carried on in_ready and out_ready.
interface alu_issue_ctrl_if;
    // decode -> sequencer
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    // sequencer <-> ALU
    logic [4:0]  alu_sel;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_dataD;
    logic        alu_ready;
    // sequencer -> writeback
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;

    // Sequencer side
    modport slave (
        input  in_valid, in_sel, in_a, in_b, in_rd, alu_dataD, alu_ready, out_ready,
        output in_ready, alu_sel, alu_dataA, alu_dataB, out_valid, out_data, out_rd, out_err
    );

    // Environment side (decode, ALU, writeback)
    modport master (
        output in_valid, in_sel, in_a, in_b, in_rd, alu_dataD, alu_ready, out_ready,
        input  in_ready, alu_sel, alu_dataA, alu_dataB, out_valid, out_data, out_rd, out_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: registers decoded ops, holds ALU operands, collects and presents results.
// Latency: single-cycle ops out_valid 2 cycles after accept; MUL/DIV wait on alu_ready (timeout MAX_WAIT).
// Backpressure: in_ready low while busy; in RESULT in_ready follows out_ready. Optional DIV_ZERO_BYPASS_EN.
module alu_issue_ctrl #(
    parameter int MAX_WAIT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    alu_issue_ctrl_if.slave bus,
    output logic            busy
);
    localparam int            CW           = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST    = CW'(MAX_WAIT - 1);
    localparam logic [31:0]   TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [4:0]    sel_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [4:0]    rd_q;
    logic          illegal_q;
    logic [31:0]   out_data_q;
    logic [4:0]    out_rd_q;
    logic          out_err_q;
    logic [CW-1:0] wait_cnt;

    logic          in_ready_c;
    logic          accept;
    logic          cap_alu;
    logic          cap_timeout;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          in_legal;
    logic          in_bypass;
    logic          in_multi;
    logic [31:0]   exec_data;

    // Decode of the legal ALU op codes; anything else completes on the EXEC path flagged as an error.
    always_comb begin
        in_legal = (bus.in_sel <= 5'h0D)
                || ((bus.in_sel >= 5'h12) && (bus.in_sel <= 5'h15))
                || (bus.in_sel == 5'h18) || (bus.in_sel == 5'h19)
                || (bus.in_sel == 5'h1E) || (bus.in_sel == 5'h1F);
    end

`ifdef DIV_ZERO_BYPASS_EN
    logic op_bypass;

    // Divide-by-zero has a fixed architectural result, so the divider is not waited on.
    assign in_bypass = (bus.in_sel >= 5'h12) && (bus.in_sel <= 5'h15) && (bus.in_b == 32'd0);
    // sel[2] separates REM/REMU (dividend passes through) from DIV/DIVU (all ones).
    assign exec_data = op_bypass ? (sel_q[2] ? a_q : 32'hFFFF_FFFF) : bus.alu_dataD;

    // Remembers that the op in flight completes without the divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_bypass <= 1'b0;
        end else if (accept) begin
            op_bypass <= in_bypass;
        end
    end
`else
    assign in_bypass = 1'b0;
    assign exec_data = bus.alu_dataD;
`endif

    // Only legal ops with sel[4] set go through the SETTLE/WAIT handshake with the ALU.
    assign in_multi = bus.in_sel[4] && in_legal && !in_bypass;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, input handshake and capture strobes; flush overrides everything.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        accept      = 1'b0;
        cap_alu     = 1'b0;
        cap_timeout = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
            end
            EXEC: begin
                cap_alu   = 1'b1;
                state_nxt = RESULT;
            end
            SETTLE: begin
                // alu_ready may still be high from the previous op here, so it is ignored.
                cnt_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.alu_ready) begin
                    cap_alu   = 1'b1;
                    state_nxt = RESULT;
                end else if (wait_cnt == WAIT_LAST) begin
                    cap_timeout = 1'b1;
                    state_nxt   = RESULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESULT: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (flush) begin
            in_ready_c  = 1'b0;
            cap_alu     = 1'b0;
            cap_timeout = 1'b0;
            cnt_inc     = 1'b0;
            cnt_clr     = 1'b1;
        end

        accept = bus.in_valid && in_ready_c;
        if (accept) begin
            state_nxt = in_multi ? SETTLE : EXEC;
        end
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand/result registers and WAIT cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q      <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rd_q       <= 5'd0;
            illegal_q  <= 1'b0;
            out_data_q <= 32'd0;
            out_rd_q   <= 5'd0;
            out_err_q  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (accept) begin
                sel_q     <= bus.in_sel;
                a_q       <= bus.in_a;
                b_q       <= bus.in_b;
                rd_q      <= bus.in_rd;
                illegal_q <= !in_legal;
            end
            if (cap_alu) begin
                out_data_q <= exec_data;
                out_rd_q   <= rd_q;
                out_err_q  <= illegal_q;
            end else if (cap_timeout) begin
                out_data_q <= TIMEOUT_DATA;
                out_rd_q   <= rd_q;
                out_err_q  <= 1'b1;
            end
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.alu_sel   = sel_q;
    assign bus.alu_dataA = a_q;
    assign bus.alu_dataB = b_q;
    assign bus.out_valid = (state == RESULT);
    assign bus.out_data  = out_data_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_err   = out_err_q;
    assign busy          = (state != IDLE);
endmodule
